// File: rtl/mem_load_unit_pkg.sv
// Shared load-unit types: load widths, FSM state codes and the alignment rule.
package mem_load_unit_pkg;

   typedef enum logic [2:0] {
      LOAD_BYTE   = 3'b000,
      LOAD_HALF   = 3'b001,
      LOAD_WORD   = 3'b010,
      LOAD_BYTE_U = 3'b100,
      LOAD_HALF_U = 3'b101
   } load_t;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_REQ   = 3'd1;
   localparam logic [2:0] ST_WAIT  = 3'd2;
   localparam logic [2:0] ST_DONE  = 3'd3;
   localparam logic [2:0] ST_DRAIN = 3'd4;

   // fun3[1:0] selects the access size; 011/110/111 fall into the word case.
   function automatic logic is_misaligned(input logic [2:0] fun3, input logic [1:0] off);
      logic mis;
      case (fun3[1:0])
         2'b00:   mis = 1'b0;
         2'b01:   mis = off[0];
         default: mis = |off;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/mem_load_unit_align_ext.sv
// Combinational byte/halfword lane select and sign/zero extension of a read word.
module load_align_ext
   import mem_load_unit_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  off_i,
   input  logic [2:0]  fun3_i,
   output logic [31:0] data_o
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;
   logic        sign_en;

   always_comb begin
      byte_v  = rdata_i[{off_i, 3'b000} +: 8];
      half_v  = rdata_i[{off_i[1], 4'b0000} +: 16];
      sign_en = ~fun3_i[2];
      case (fun3_i[1:0])
         2'b00:   data_o = {{24{sign_en & byte_v[7]}}, byte_v};
         2'b01:   data_o = {{16{sign_en & half_v[15]}}, half_v};
         default: data_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/mem_load_unit.sv
// MEM-stage load port: issues one word read on the data bus, extracts the addressed
// lane, stalls the pipeline while the read is outstanding and reports bus timeouts.
module mem_load_unit
   import mem_load_unit_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid_i,
   input  logic [31:0] req_addr_i,
   input  logic [2:0]  req_fun3_i,
   input  logic [4:0]  req_rd_i,
   input  logic        flush_i,
   output logic        stall_o,
   output logic        rsp_valid_o,
   output logic [31:0] rsp_data_o,
   output logic [4:0]  rsp_rd_o,
   output logic        misalign_o,
   output logic        bus_err_o,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   input  logic        mem_ready_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   output logic [2:0]  dbg_state_o
);

   // Bus handshake: a read is accepted on a cycle with mem_req_o & mem_ready_i; mem_req_o and
   // mem_addr_o stay stable until then. Exactly one mem_rvalid_i pulse follows each accepted
   // read, at least one cycle later; rsp_valid_o is a single-cycle pulse with no back-pressure.

   logic [2:0]       state_q, state_d;
   logic [31:0]      addr_q, addr_d;
   logic [2:0]       fun3_q, fun3_d;
   logic [4:0]       rd_q, rd_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
   logic             drain_q, drain_d;
   logic [31:0]      rsp_data_q, rsp_data_d;
   logic [4:0]       rsp_rd_q, rsp_rd_d;
   logic [31:0]      ext_data;
   logic             req_aligned;
   logic             timeout_hit;

   load_align_ext u_align (
      .rdata_i (mem_rdata_i),
      .off_i   (addr_q[1:0]),
      .fun3_i  (fun3_q),
      .data_o  (ext_data)
   );

   assign req_aligned = ~is_misaligned(req_fun3_i, req_addr_i[1:0]);
   assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      fun3_d     = fun3_q;
      rd_d       = rd_q;
      cnt_d      = cnt_q;
      err_d      = err_q;
      drain_d    = drain_q;
      rsp_data_d = rsp_data_q;
      rsp_rd_d   = rsp_rd_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid_i && req_aligned && !flush_i) begin
               state_d = ST_REQ;
               addr_d  = req_addr_i;
               fun3_d  = req_fun3_i;
               rd_d    = req_rd_i;
               cnt_d   = '0;
            end
         end
         ST_REQ: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (flush_i) begin
               state_d = mem_ready_i ? ST_DRAIN : ST_IDLE;
            end else if (timeout_hit) begin
               // A read accepted on the timeout cycle still owes a response; drain it later.
               state_d    = ST_DONE;
               err_d      = 1'b1;
               drain_d    = mem_ready_i;
               rsp_data_d = '0;
               rsp_rd_d   = rd_q;
            end else if (mem_ready_i) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (mem_rvalid_i) begin
               if (flush_i) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d    = ST_DONE;
                  err_d      = 1'b0;
                  drain_d    = 1'b0;
                  rsp_data_d = ext_data;
                  rsp_rd_d   = rd_q;
               end
            end else if (flush_i) begin
               state_d = ST_DRAIN;
            end else if (timeout_hit) begin
               state_d    = ST_DONE;
               err_d      = 1'b1;
               drain_d    = 1'b1;
               rsp_data_d = '0;
               rsp_rd_d   = rd_q;
            end
         end
         ST_DONE: begin
            drain_d = 1'b0;
            state_d = (drain_q && !mem_rvalid_i) ? ST_DRAIN : ST_IDLE;
         end
         ST_DRAIN: begin
            if (mem_rvalid_i) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         fun3_q     <= '0;
         rd_q       <= '0;
         cnt_q      <= '0;
         err_q      <= 1'b0;
         drain_q    <= 1'b0;
         rsp_data_q <= '0;
         rsp_rd_q   <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         fun3_q     <= fun3_d;
         rd_q       <= rd_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
         drain_q    <= drain_d;
         rsp_data_q <= rsp_data_d;
         rsp_rd_q   <= rsp_rd_d;
      end
   end

   assign mem_req_o   = (state_q == ST_REQ);
   assign mem_addr_o  = {addr_q[31:2], 2'b00};
   assign rsp_valid_o = (state_q == ST_DONE) && !flush_i;
   assign bus_err_o   = rsp_valid_o && err_q;
   assign rsp_data_o  = rsp_data_q;
   assign rsp_rd_o    = rsp_rd_q;
   assign misalign_o  = (state_q == ST_IDLE) && req_valid_i && !req_aligned;
   assign stall_o     = ((state_q == ST_IDLE) && req_valid_i && req_aligned)
                      || (state_q == ST_REQ) || (state_q == ST_WAIT)
                      || ((state_q == ST_DRAIN) && req_valid_i);
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_load_unit.sv
// Randomized and directed bench for mem_load_unit with a reference model and scoreboard.
module tb_mem_load_unit;
   import mem_load_unit_pkg::*;

   localparam int TO = 16;

   logic        clk, reset;
   logic        req_valid_i, flush_i, mem_ready_i, mem_rvalid_i;
   logic [31:0] req_addr_i, mem_rdata_i;
   logic [2:0]  req_fun3_i;
   logic [4:0]  req_rd_i;
   logic        stall_o, rsp_valid_o, misalign_o, bus_err_o, mem_req_o;
   logic [31:0] rsp_data_o, mem_addr_o;
   logic [4:0]  rsp_rd_o;
   logic [2:0]  dbg_state_o;

   int n_checks = 0;
   int n_pass = 0;
   int cyc = 0;
   int rsp_count = 0;
   int last_rsp_cyc = 0;
   int ready_dly = 0;
   int rv_dly = 1;
   logic [31:0] mem_word = '0;
   logic [31:0] exp_addr = '0;
   logic [31:0] cur_addr = '0;
   logic [2:0]  cur_fun3 = '0;
   logic [37:0] exp_q[$];

   mem_load_unit #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
      .clk(clk), .reset(reset),
      .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .req_fun3_i(req_fun3_i),
      .req_rd_i(req_rd_i), .flush_i(flush_i), .stall_o(stall_o),
      .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_rd_o(rsp_rd_o),
      .misalign_o(misalign_o), .bus_err_o(bus_err_o), .mem_req_o(mem_req_o),
      .mem_addr_o(mem_addr_o), .mem_ready_i(mem_ready_i), .mem_rvalid_i(mem_rvalid_i),
      .mem_rdata_i(mem_rdata_i), .dbg_state_o(dbg_state_o)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic int unsigned acc_size(input logic [2:0] f3);
      if (f3[1:0] == 2'b00) return 1;
      if (f3[1:0] == 2'b01) return 2;
      return 4;
   endfunction

   function automatic bit ref_misaligned(input logic [31:0] a, input logic [2:0] f3);
      return (a % acc_size(f3)) != 0;
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [31:0] a,
                                            input logic [2:0] f3);
      int unsigned off, v;
      bit sgn;
      off = a % 4;
      sgn = (f3[2] == 1'b0);
      case (acc_size(f3))
         1: begin
            v = (w >> (8 * off)) % 256;
            if (sgn && v >= 128) v = v + 32'hFFFF_FF00;
         end
         2: begin
            v = (w >> (16 * (off / 2))) % 65536;
            if (sgn && v >= 32768) v = v + 32'hFFFF_0000;
         end
         default: v = w;
      endcase
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   // ---------------- driver tasks ----------------
   task automatic start_load(input logic [31:0] addr, input logic [2:0] f3, input logic [4:0] rd,
                             input logic [31:0] word, input int rdly, input int vdly,
                             input bit want_rsp);
      logic err;
      req_valid_i = 1'b1;
      req_addr_i  = addr;
      req_fun3_i  = f3;
      req_rd_i    = rd;
      cur_addr    = addr;
      cur_fun3    = f3;
      exp_addr    = addr;
      mem_word    = word;
      ready_dly   = rdly;
      rv_dly      = vdly;
      // REQ+WAIT cycles needed = rdly+1 (REQ) + vdly (WAIT); more than TO means a timeout.
      err = (rdly + 1 + vdly > TO);
      if (want_rsp && !ref_misaligned(addr, f3))
         exp_q.push_back({err, rd, err ? 32'd0 : ref_load(word, addr, f3)});
   endtask

   task automatic wait_retire(output int stalls);
      bit done;
      done = 1'b0;
      stalls = 0;
      for (int i = 0; i < 300 && !done; i++) begin
         @(negedge clk);
         if (!stall_o) begin
            done = 1'b1;
            check("misalign_at_retire", 32'(misalign_o), 32'(ref_misaligned(cur_addr, cur_fun3)));
            check("mem_req_at_retire", 32'(mem_req_o), 32'd0);
         end else begin
            stalls++;
         end
      end
      if (!done) begin
         n_checks++;
         $display("FAIL retire_timeout: stall_o still 1 after 300 cycles, required 0");
      end
      @(posedge clk); #1;
      req_valid_i = 1'b0;
   endtask

   task automatic run_load(input logic [31:0] addr, input logic [2:0] f3, input logic [4:0] rd,
                           input logic [31:0] word, input int rdly, input int vdly,
                           output int stalls);
      start_load(addr, f3, rd, word, rdly, vdly, 1'b1);
      wait_retire(stalls);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_stall"}, 32'(stall_o), 32'd0);
      check({tag, "_rsp_valid"}, 32'(rsp_valid_o), 32'd0);
      check({tag, "_rsp_data"}, rsp_data_o, 32'd0);
      check({tag, "_rsp_rd"}, 32'(rsp_rd_o), 32'd0);
      check({tag, "_misalign"}, 32'(misalign_o), 32'd0);
      check({tag, "_bus_err"}, 32'(bus_err_o), 32'd0);
      check({tag, "_mem_req"}, 32'(mem_req_o), 32'd0);
      check({tag, "_mem_addr"}, mem_addr_o, 32'd0);
   endtask

   // ---------------- memory responder ----------------
   initial begin
      int req_cnt;
      bit pend;
      int rv_cnt;
      logic [31:0] pend_word, req_addr0;
      req_cnt = 0; pend = 1'b0; rv_cnt = 0; pend_word = '0; req_addr0 = '0;
      mem_ready_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
      forever begin
         @(posedge clk); #1;
         mem_ready_i  = 1'b0;
         mem_rvalid_i = 1'b0;
         mem_rdata_i  = $urandom;
         if (pend) begin
            rv_cnt--;
            if (rv_cnt == 0) begin
               mem_rvalid_i = 1'b1;
               mem_rdata_i  = pend_word;
               pend         = 1'b0;
            end
         end
         if (mem_req_o && !reset) begin
            if (req_cnt == 0) begin
               req_addr0 = mem_addr_o;
               check("mem_addr", mem_addr_o, exp_addr & ~32'h3);
            end else begin
               check("mem_addr_stable", mem_addr_o, req_addr0);
            end
            if (req_cnt == ready_dly) begin
               mem_ready_i = 1'b1;
               pend        = 1'b1;
               rv_cnt      = rv_dly;
               pend_word   = mem_word;
            end
            req_cnt++;
         end else begin
            req_cnt = 0;
         end
      end
   end

   // ---------------- scoreboard monitor ----------------
   initial begin
      logic [37:0] e;
      forever begin
         @(negedge clk);
         if (rsp_valid_o) begin
            rsp_count++;
            last_rsp_cyc = cyc;
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_rsp: rsp_valid_o=1 data 0x%08h rd %0d, required no response",
                        rsp_data_o, rsp_rd_o);
            end else begin
               e = exp_q.pop_front();
               check("rsp_data", rsp_data_o, e[31:0]);
               check("rsp_rd", 32'(rsp_rd_o), 32'(e[36:32]));
               check("rsp_bus_err", 32'(bus_err_o), 32'(e[37]));
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int st, c0, r0, rdly, vdly;
      logic [31:0] addr;
      logic [2:0]  f3;
      logic [2:0]  f3_tab [8];
      f3_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
      reset = 1'b1; req_valid_i = 1'b0; flush_i = 1'b0;
      req_addr_i = '0; req_fun3_i = '0; req_rd_i = '0;
      repeat (3) @(negedge clk);
      check_outputs_zero("reset");
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      // Minimum-latency LW
      start_load(32'h100, 3'b010, 5'd5, 32'hDEAD_BEEF, 0, 1, 1'b1);
      c0 = cyc;
      wait_retire(st);
      check("min_lat_stall_cycles", 32'(st), 32'd3);
      check("min_lat_rsp_cycle", 32'(last_rsp_cyc - c0), 32'd3);

      // Lane extraction from one word
      run_load(32'h103, 3'b000, 5'd1, 32'h8011_2233, 0, 1, st);
      run_load(32'h103, 3'b100, 5'd2, 32'h8011_2233, 1, 2, st);
      run_load(32'h102, 3'b001, 5'd3, 32'h8011_2233, 0, 1, st);
      run_load(32'h100, 3'b101, 5'd4, 32'h8011_2233, 2, 1, st);

      // Misaligned LW: trap in the same cycle, no bus access, no stall
      start_load(32'h102, 3'b010, 5'd8, 32'h1234_5678, 0, 1, 1'b1);
      @(negedge clk);
      check("misalign_lw", 32'(misalign_o), 32'd1);
      check("misalign_stall", 32'(stall_o), 32'd0);
      check("misalign_mem_req", 32'(mem_req_o), 32'd0);
      @(posedge clk); #1;
      req_valid_i = 1'b0;
      repeat (3) @(posedge clk); #1;
      run_load(32'h101, 3'b001, 5'd9, 32'h1234_5678, 0, 1, st);

      // Slow bus: ready after 3 idle cycles, rvalid 5 cycles after accept
      r0 = rsp_count;
      run_load(32'h140, 3'b010, 5'd6, 32'hA5A5_5A5A, 3, 5, st);
      repeat (3) @(posedge clk); #1;
      check("slow_single_pulse", 32'(rsp_count - r0), 32'd1);
      check("slow_stall_cycles", 32'(st), 32'd10);

      // Timeout in WAIT, late rvalid drained before the next load
      run_load(32'h400, 3'b010, 5'd11, 32'h1234_5678, 0, 20, st);
      check("timeout_stall_cycles", 32'(st), 32'd17);
      run_load(32'h404, 3'b010, 5'd12, 32'h0BAD_F00D, 0, 1, st);
      check("drain_then_load_stall", 32'(st), 32'd7);
      // Timeout in REQ: memory never accepts
      run_load(32'h408, 3'b010, 5'd13, 32'h5555_AAAA, 100, 1, st);
      check("req_timeout_stall", 32'(st), 32'd17);
      run_load(32'h40C, 3'b001, 5'd14, 32'hFFFF_7FFF, 0, 2, st);

      // Flush in WAIT with the next load queued behind the drain
      start_load(32'h200, 3'b010, 5'd7, 32'h1111_1111, 0, 4, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      flush_i = 1'b1; req_valid_i = 1'b0;
      @(posedge clk); #1;
      flush_i = 1'b0;
      start_load(32'h204, 3'b101, 5'd9, 32'hCAFE_1234, 0, 1, 1'b1);
      @(negedge clk);
      check("flush_wait_drain_state", 32'(dbg_state_o), 32'(ST_DRAIN));
      check("flush_wait_drain_stall", 32'(stall_o), 32'd1);
      wait_retire(st);

      // Flush in REQ without and with acceptance
      start_load(32'h300, 3'b010, 5'd3, 32'h2222_2222, 5, 1, 1'b0);
      @(posedge clk); #1;
      flush_i = 1'b1; req_valid_i = 1'b0;
      @(posedge clk); #1;
      flush_i = 1'b0;
      @(negedge clk);
      check("flush_req_idle", 32'(dbg_state_o), 32'(ST_IDLE));
      @(posedge clk); #1;
      start_load(32'h310, 3'b010, 5'd3, 32'h3333_3333, 0, 3, 1'b0);
      @(posedge clk); #1;
      flush_i = 1'b1; req_valid_i = 1'b0;
      @(posedge clk); #1;
      flush_i = 1'b0;
      @(negedge clk);
      check("flush_req_accept_drain", 32'(dbg_state_o), 32'(ST_DRAIN));
      @(posedge clk); #1;
      run_load(32'h320, 3'b000, 5'd15, 32'h0000_7F00, 0, 1, st);

      // Reset in the middle of WAIT; the stale rvalid afterwards must be ignored
      start_load(32'h500, 3'b010, 5'd10, 32'h7777_8888, 0, 6, 1'b1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b1; req_valid_i = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check_outputs_zero("mid_reset");
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (10) @(posedge clk); #1;

      // Randomized loads, occasionally slow enough to time out
      for (int i = 0; i < 60; i++) begin
         f3   = f3_tab[$urandom_range(0, 7)];
         addr = $urandom;
         if ($urandom_range(0, 3) != 0) addr = addr & ~32'(acc_size(f3) - 1);
         rdly = $urandom_range(0, 4);
         vdly = ($urandom_range(0, 7) == 0) ? $urandom_range(12, 18) : $urandom_range(1, 6);
         run_load(addr, f3, 5'($urandom_range(0, 31)), $urandom, rdly, vdly, st);
      end

      repeat (30) @(posedge clk); #1;
      check("exp_q_empty", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
